// File: rtl/uartlite_rx_gen2.sv
// UART-lite receiver: oversampled majority-vote framing (5-9 data bits, parity, 1-2 stop bits)
// feeding a first-word-fall-through FIFO with break, overrun, threshold and idle-timeout status.
module uartlite_rx_gen2 #(
    parameter int C_DATA_BITS      = 8,
    parameter int C_PARITY         = 0,
    parameter int C_STOP_BITS      = 1,
    parameter int C_OVERSAMPLE     = 16,
    parameter int C_FIFO_DEPTH     = 16,
    parameter int C_FIFO_THRESHOLD = 8,
    parameter int C_IDLE_CHARS     = 4
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            En_Baud,
    input  logic                            RX,
    input  logic                            Read_RX_FIFO,
    input  logic                            Reset_RX_FIFO,
    output logic [C_DATA_BITS-1:0]          RX_Data,
    output logic                            RX_Data_Present,
    output logic                            RX_Buffer_Full,
    output logic [$clog2(C_FIFO_DEPTH):0]   RX_Fill_Level,
    output logic                            RX_Threshold_Hit,
    output logic                            RX_Frame_Error,
    output logic                            RX_Parity_Error,
    output logic                            RX_Overrun_Error,
    output logic                            RX_Break,
    output logic                            RX_Idle_Timeout
);

    localparam int AW         = $clog2(C_FIFO_DEPTH);
    localparam int LW         = AW + 1;
    localparam int TW         = $clog2(C_OVERSAMPLE);
    localparam int FRAME_BITS = 1 + C_DATA_BITS + ((C_PARITY != 0) ? 1 : 0) + C_STOP_BITS;
    localparam int IDLE_LIMIT = C_IDLE_CHARS * C_OVERSAMPLE * FRAME_BITS;
    localparam int IW         = $clog2(IDLE_LIMIT + 1);

    localparam logic [TW-1:0] T_S0  = TW'(C_OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(C_OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC = TW'(C_OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(C_OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t                 state;
    logic                   rx_meta, rxs;
    logic [TW-1:0]          tcnt;
    logic                   v0, v1;
    logic                   maj;
    logic [C_DATA_BITS-1:0] shreg;
    logic [3:0]             bcnt;
    logic                   stop_cnt;
    logic                   par_bad;
    logic                   all_zero;
    logic                   par_exp;
    logic                   wr_req;

    logic [C_DATA_BITS-1:0] mem [C_FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [LW-1:0]          level;
    logic                   empty, full, pop, push, start_det;
    logic [IW-1:0]          idle_cnt;

    // Two-flop synchroniser; idles high so a reset never looks like a start bit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
        end
    end

    assign maj = (v0 & v1) | (v0 & rxs) | (v1 & rxs);

    always_comb begin
        case (C_PARITY)
            1:       par_exp = ^shreg;
            2:       par_exp = ~^shreg;
            3:       par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    // Frame FSM; status pulses are registered so they appear the cycle after the last stop decision.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state           <= IDLE;
            tcnt            <= '0;
            v0              <= 1'b1;
            v1              <= 1'b1;
            shreg           <= '0;
            bcnt            <= '0;
            stop_cnt        <= 1'b0;
            par_bad         <= 1'b0;
            all_zero        <= 1'b0;
            wr_req          <= 1'b0;
            RX_Parity_Error <= 1'b0;
            RX_Frame_Error  <= 1'b0;
            RX_Break        <= 1'b0;
        end else begin
            wr_req          <= 1'b0;
            RX_Parity_Error <= 1'b0;
            RX_Frame_Error  <= 1'b0;
            RX_Break        <= 1'b0;
            if (En_Baud) begin
                if (state != IDLE)
                    tcnt <= tcnt + 1'b1;
                if (tcnt == T_S0)
                    v0 <= rxs;
                if (tcnt == T_S1)
                    v1 <= rxs;
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state <= START;
                            tcnt  <= '0;
                        end
                    end
                    START: begin
                        if (tcnt == T_DEC && maj) begin
                            state <= IDLE;
                        end else if (tcnt == T_END) begin
                            state    <= DATA;
                            bcnt     <= '0;
                            all_zero <= 1'b1;
                            par_bad  <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (tcnt == T_DEC) begin
                            shreg <= {maj, shreg[C_DATA_BITS-1:1]};
                            if (maj)
                                all_zero <= 1'b0;
                        end
                        if (tcnt == T_END) begin
                            if (bcnt == 4'(C_DATA_BITS - 1)) begin
                                bcnt     <= '0;
                                stop_cnt <= 1'b0;
                                state    <= (C_PARITY != 0) ? PARITY : STOP;
                            end else begin
                                bcnt <= bcnt + 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        if (tcnt == T_DEC) begin
                            par_bad <= (maj != par_exp);
                            if (maj)
                                all_zero <= 1'b0;
                        end
                        if (tcnt == T_END)
                            state <= STOP;
                    end
                    STOP: begin
                        if (tcnt == T_DEC) begin
                            if (!maj) begin
                                // A low stop bit ends the frame; break only if nothing was ever high.
                                state <= WAIT_HIGH;
                                if (all_zero && !stop_cnt)
                                    RX_Break <= 1'b1;
                                else
                                    RX_Frame_Error <= 1'b1;
                            end else if (stop_cnt == 1'(C_STOP_BITS - 1)) begin
                                state           <= IDLE;
                                wr_req          <= 1'b1;
                                RX_Parity_Error <= par_bad;
                            end else begin
                                stop_cnt <= 1'b1;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (rxs)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign empty     = (level == '0);
    assign full      = (level == LW'(C_FIFO_DEPTH));
    assign pop       = Read_RX_FIFO && !empty;
    assign push      = wr_req && !Reset_RX_FIFO && (!full || pop);
    assign start_det = En_Baud && (state == IDLE) && !rxs;

    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr] <= shreg;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            level            <= '0;
            RX_Overrun_Error <= 1'b0;
        end else begin
            RX_Overrun_Error <= wr_req && !Reset_RX_FIFO && full && !pop;
            if (Reset_RX_FIFO) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idle_cnt <= '0;
        end else if (start_det || pop || Reset_RX_FIFO || empty) begin
            idle_cnt <= '0;
        end else if (En_Baud && state == IDLE && rxs && idle_cnt != IW'(IDLE_LIMIT)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign RX_Data          = empty ? '0 : mem[rd_ptr];
    assign RX_Data_Present  = !empty;
    assign RX_Buffer_Full   = full;
    assign RX_Fill_Level    = level;
    assign RX_Threshold_Hit = (level >= LW'(C_FIFO_THRESHOLD));
    assign RX_Idle_Timeout  = (idle_cnt == IW'(IDLE_LIMIT));

endmodule

// File: tb/tb_uartlite_rx_gen2.sv
// Bench for uartlite_rx_gen2: instance A is 8N1 / depth 16, instance B is 8E2 / depth 4.
// Frames are driven tick-aligned so status can be sampled exactly one and two cycles after the last stop decision.
module tb_uartlite_rx_gen2;

    localparam int D_A = 16, THR_A = 8;
    localparam int D_B = 4,  THR_B = 3;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [1:0] bc = 2'd0;
    logic       En_Baud;

    logic       rx_a, rd_a, fl_a, pres_a, full_a, thr_a, fe_a, pe_a, ov_a, br_a, to_a;
    logic [7:0] data_a;
    logic [4:0] lvl_a;
    logic       rx_b, rd_b, fl_b, pres_b, full_b, thr_b, fe_b, pe_b, ov_b, br_b, to_b;
    logic [7:0] data_b;
    logic [2:0] lvl_b;

    always #5 Clk = ~Clk;
    always @(posedge Clk) bc <= bc + 2'd1;
    assign En_Baud = (bc == 2'd3);

    uartlite_rx_gen2 dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .En_Baud(En_Baud), .RX(rx_a),
        .Read_RX_FIFO(rd_a), .Reset_RX_FIFO(fl_a), .RX_Data(data_a),
        .RX_Data_Present(pres_a), .RX_Buffer_Full(full_a), .RX_Fill_Level(lvl_a),
        .RX_Threshold_Hit(thr_a), .RX_Frame_Error(fe_a), .RX_Parity_Error(pe_a),
        .RX_Overrun_Error(ov_a), .RX_Break(br_a), .RX_Idle_Timeout(to_a)
    );

    uartlite_rx_gen2 #(
        .C_PARITY(1), .C_STOP_BITS(2), .C_FIFO_DEPTH(D_B),
        .C_FIFO_THRESHOLD(THR_B), .C_IDLE_CHARS(1)
    ) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .En_Baud(En_Baud), .RX(rx_b),
        .Read_RX_FIFO(rd_b), .Reset_RX_FIFO(fl_b), .RX_Data(data_b),
        .RX_Data_Present(pres_b), .RX_Buffer_Full(full_b), .RX_Fill_Level(lvl_b),
        .RX_Threshold_Hit(thr_b), .RX_Frame_Error(fe_b), .RX_Parity_Error(pe_b),
        .RX_Overrun_Error(ov_b), .RX_Break(br_b), .RX_Idle_Timeout(to_b)
    );

    // Pulse counters over the whole run
    int c_pe[2] = '{0, 0}, c_fe[2] = '{0, 0}, c_br[2] = '{0, 0}, c_ov[2] = '{0, 0};
    int e_pe[2] = '{0, 0}, e_fe[2] = '{0, 0}, e_br[2] = '{0, 0}, e_ov[2] = '{0, 0};
    always @(posedge Clk) begin
        if (pe_a) c_pe[0] <= c_pe[0] + 1;
        if (fe_a) c_fe[0] <= c_fe[0] + 1;
        if (br_a) c_br[0] <= c_br[0] + 1;
        if (ov_a) c_ov[0] <= c_ov[0] + 1;
        if (pe_b) c_pe[1] <= c_pe[1] + 1;
        if (fe_b) c_fe[1] <= c_fe[1] + 1;
        if (br_b) c_br[1] <= c_br[1] + 1;
        if (ov_b) c_ov[1] <= c_ov[1] + 1;
    end

    logic       cur = 1'b0;
    logic       m_pres, m_full, m_thr, m_fe, m_pe, m_ov, m_br, m_to;
    logic [7:0] m_data;
    logic [4:0] m_lvl;
    assign m_pres = cur ? pres_b : pres_a;
    assign m_full = cur ? full_b : full_a;
    assign m_thr  = cur ? thr_b  : thr_a;
    assign m_fe   = cur ? fe_b   : fe_a;
    assign m_pe   = cur ? pe_b   : pe_a;
    assign m_ov   = cur ? ov_b   : ov_a;
    assign m_br   = cur ? br_b   : br_a;
    assign m_to   = cur ? to_b   : to_a;
    assign m_data = cur ? data_b : data_a;
    assign m_lvl  = cur ? {2'b00, lvl_b} : lvl_a;

    logic       s1_pres, s1_fe, s1_pe, s1_br, s2_pres, s2_ov;
    logic [4:0] s1_lvl, s2_lvl;
    logic [7:0] s1_data;

    logic [7:0] qa[$], qb[$];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Leaves us just after the edge following a tick edge, so a change is seen by the DUT on the next tick.
    task automatic align();
        do wait_clk(1); while (bc != 2'd1);
    endtask

    task automatic set_rx(input logic v);
        if (cur) rx_b = v; else rx_a = v;
    endtask

    task automatic set_rd(input logic v);
        if (cur) rd_b = v; else rd_a = v;
    endtask

    task automatic send_frame(input logic sel, input logic [7:0] d, input logic par_on, input logic par,
                              input logic [1:0] stops, input int nstop, input logic pop_t1);
        int last;
        cur = sel;
        align();
        set_rx(1'b0);
        wait_clk(64);
        for (int i = 0; i < 8; i++) begin
            set_rx(d[i]);
            wait_clk(64);
        end
        if (par_on) begin
            set_rx(par);
            wait_clk(64);
        end
        last = (nstop == 2 && stops[0]) ? 1 : 0;
        for (int i = 0; i <= last; i++) begin
            set_rx(stops[i]);
            if (i < last) wait_clk(64);
        end
        // 43 edges after the bit edge is the decision tick (sample 10 of 16 plus synchroniser)
        wait_clk(43);
        s1_pres = m_pres; s1_fe = m_fe; s1_pe = m_pe; s1_br = m_br;
        s1_lvl = m_lvl;   s1_data = m_data;
        if (pop_t1) set_rd(1'b1);
        wait_clk(1);
        set_rd(1'b0);
        s2_pres = m_pres; s2_lvl = m_lvl; s2_ov = m_ov;
        wait_clk(20);
    endtask

    task automatic good_char(input logic sel, input logic [7:0] d, input logic bad_par, input logic pop_t1);
        int lvl0, nl, dep, thr;
        logic popped, wr;
        logic [7:0] head;
        dep  = sel ? D_B : D_A;
        thr  = sel ? THR_B : THR_A;
        lvl0 = sel ? qb.size() : qa.size();
        head = (lvl0 == 0) ? 8'h00 : (sel ? qb[0] : qa[0]);
        send_frame(sel, d, sel, (^d) ^ bad_par, 2'b11, sel ? 2 : 1, pop_t1);
        popped = pop_t1 && (lvl0 > 0);
        wr     = (lvl0 < dep) || popped;
        nl     = lvl0 - int'(popped) + int'(wr);
        chk($sformatf("pe_t1_%0d", sel), s1_pe, bad_par);
        chk($sformatf("fe_t1_%0d", sel), s1_fe, 0);
        chk($sformatf("br_t1_%0d", sel), s1_br, 0);
        chk($sformatf("pres_t1_%0d", sel), s1_pres, lvl0 != 0);
        chk($sformatf("lvl_t1_%0d", sel), s1_lvl, lvl0);
        chk($sformatf("head_t1_%0d", sel), s1_data, head);
        chk($sformatf("lvl_t2_%0d", sel), s2_lvl, nl);
        chk($sformatf("pres_t2_%0d", sel), s2_pres, nl != 0);
        chk($sformatf("ovr_t2_%0d", sel), s2_ov, !wr);
        chk($sformatf("thr_%0d", sel), m_thr, nl >= thr);
        chk($sformatf("full_%0d", sel), m_full, nl == dep);
        if (sel) begin
            if (popped) void'(qb.pop_front());
            if (wr) qb.push_back(d);
        end else begin
            if (popped) void'(qa.pop_front());
            if (wr) qa.push_back(d);
        end
        if (bad_par) e_pe[sel]++;
        if (!wr) e_ov[sel]++;
    endtask

    task automatic bad_frame_a(input logic [7:0] d);
        int lvl0;
        lvl0 = qa.size();
        send_frame(1'b0, d, 1'b0, 1'b0, 2'b00, 1, 1'b0);
        chk("bad_br_t1", s1_br, d == 8'h00);
        chk("bad_fe_t1", s1_fe, d != 8'h00);
        chk("bad_pe_t1", s1_pe, 0);
        chk("bad_lvl_t2", s2_lvl, lvl0);
        if (d == 8'h00) e_br[0]++; else e_fe[0]++;
    endtask

    task automatic pop_chk(input logic sel);
        int n;
        logic [7:0] e;
        cur = sel;
        n = sel ? qb.size() : qa.size();
        e = (n == 0) ? 8'h00 : (sel ? qb[0] : qa[0]);
        chk($sformatf("head_%0d", sel), m_data, e);
        chk($sformatf("lvl_%0d", sel), m_lvl, n);
        set_rd(1'b1);
        wait_clk(1);
        set_rd(1'b0);
        if (n > 0) begin
            if (sel) void'(qb.pop_front()); else void'(qa.pop_front());
        end
        chk($sformatf("lvl_after_pop_%0d", sel), m_lvl, (n > 0) ? n - 1 : 0);
    endtask

    task automatic chk_counts(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("%s_npe_%0d", tag, s), c_pe[s], e_pe[s]);
            chk($sformatf("%s_nfe_%0d", tag, s), c_fe[s], e_fe[s]);
            chk($sformatf("%s_nbr_%0d", tag, s), c_br[s], e_br[s]);
            chk($sformatf("%s_nov_%0d", tag, s), c_ov[s], e_ov[s]);
        end
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_pres"}, pres_a, 0);
        chk({tag, "_lvl"}, lvl_a, 0);
        chk({tag, "_data"}, data_a, 0);
        chk({tag, "_full"}, full_a, 0);
        chk({tag, "_thr"}, thr_a, 0);
        chk({tag, "_to"}, to_a, 0);
        chk({tag, "_err"}, {fe_a, pe_a, ov_a, br_a}, 0);
    endtask

    initial begin
        rx_a = 1'b1; rd_a = 1'b0; fl_a = 1'b0;
        rx_b = 1'b1; rd_b = 1'b0; fl_b = 1'b0;
        wait_clk(5);
        chk_zero_a("rst_a");
        chk("rst_b_pres", pres_b, 0);
        chk("rst_b_lvl", lvl_b, 0);
        chk("rst_b_err", {fe_b, pe_b, ov_b, br_b, to_b, full_b, thr_b}, 0);
        Reset_n = 1'b1;
        wait_clk(10);

        // Basic 8N1 character
        good_char(1'b0, 8'hA5, 1'b0, 1'b0);
        chk("a5_data", data_a, 8'hA5);

        // Glitch shorter than half a bit is a false start
        cur = 1'b0;
        align();
        set_rx(1'b0);
        wait_clk(20);
        set_rx(1'b1);
        wait_clk(200);
        chk("false_start_lvl", lvl_a, 1);
        good_char(1'b0, 8'h5A, 1'b0, 1'b0);
        pop_chk(1'b0);
        pop_chk(1'b0);
        chk_counts("basic");

        // Random characters across the threshold, then drain
        for (int i = 0; i < 9; i++) good_char(1'b0, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) pop_chk(1'b0);
        chk("empty_data_a", data_a, 0);

        // Break: line held low well past the frame
        bad_frame_a(8'h00);
        wait_clk(128);
        set_rx(1'b1);
        wait_clk(128);
        chk("break_lvl", lvl_a, 0);
        good_char(1'b0, 8'h3C, 1'b0, 1'b0);
        pop_chk(1'b0);

        // Framing error with non-zero data
        bad_frame_a(8'h81);
        set_rx(1'b1);
        wait_clk(64);
        good_char(1'b0, 8'($urandom), 1'b0, 1'b0);
        pop_chk(1'b0);
        chk_counts("errs_a");

        // Even parity: bad parity still stored, good parity silent
        good_char(1'b1, 8'h03, 1'b1, 1'b0);
        good_char(1'b1, 8'h03, 1'b0, 1'b0);
        // Zero data but second stop bit low is a framing error, not a break
        send_frame(1'b1, 8'h00, 1'b1, 1'b0, 2'b01, 2, 1'b0);
        chk("stop2_fe", s1_fe, 1);
        chk("stop2_br", s1_br, 0);
        chk("stop2_lvl", s2_lvl, 2);
        e_fe[1]++;
        set_rx(1'b1);
        wait_clk(64);

        // Fill to full, overrun, then a write coinciding with a pop
        good_char(1'b1, 8'($urandom), 1'b0, 1'b0);
        good_char(1'b1, 8'($urandom), 1'b0, 1'b0);
        good_char(1'b1, 8'($urandom), 1'b0, 1'b0);
        good_char(1'b1, 8'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) pop_chk(1'b1);

        // Flush
        good_char(1'b1, 8'($urandom), 1'b0, 1'b0);
        good_char(1'b1, 8'($urandom), 1'b0, 1'b0);
        cur = 1'b1;
        fl_b = 1'b1;
        wait_clk(1);
        fl_b = 1'b0;
        chk("flush_lvl", lvl_b, 0);
        chk("flush_pres", pres_b, 0);
        chk("flush_data", data_b, 0);
        qb.delete();
        chk_counts("b");

        // Idle timeout: 4 chars x 10 bits x 16 ticks; 5 ticks already counted when a frame task returns
        good_char(1'b0, 8'($urandom), 1'b0, 1'b0);
        good_char(1'b0, 8'($urandom), 1'b0, 1'b0);
        chk("to_early", to_a, 0);
        wait_clk(4 * 634);
        chk("to_639", to_a, 0);
        wait_clk(4);
        chk("to_640", to_a, 1);
        wait_clk(40);
        chk("to_hold", to_a, 1);
        pop_chk(1'b0);
        chk("to_clr", to_a, 0);
        pop_chk(1'b0);

        // Reset in the middle of a data bit
        good_char(1'b0, 8'($urandom), 1'b0, 1'b0);
        cur = 1'b0;
        align();
        set_rx(1'b0);
        wait_clk(64);
        set_rx(1'b1); wait_clk(64);
        set_rx(1'b0); wait_clk(64);
        set_rx(1'b1); wait_clk(64);
        set_rx(1'b0); wait_clk(30);
        Reset_n = 1'b0;
        wait_clk(3);
        chk_zero_a("mid_rst");
        rx_a = 1'b1;
        qa.delete();
        Reset_n = 1'b1;
        wait_clk(128);
        good_char(1'b0, 8'hC3, 1'b0, 1'b0);
        pop_chk(1'b0);
        chk_counts("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uartlite_rx_gen2.md
Name: uartlite_rx_gen2

Overview:
Parametrised next-generation UART-lite receiver for the BQ79606 daisy-chain link. It converts the oversampled serial RX line into characters with 5-9 data bits, optional parity (none/even/odd/mark/space) and 1 or 2 stop bits, using majority-vote mid-bit sampling. Characters are buffered in a built-in first-word-fall-through FIFO of parametrised depth; no vendor primitives are used. It adds break detection, a fill-level threshold and a character-idle timeout, and sits between the baud generator and the AXI-lite register front end.

Parameters:
C_DATA_BITS, 8, data bits per character, 5..9
C_PARITY, 0, 0=none 1=even 2=odd 3=mark 4=space
C_STOP_BITS, 1, stop bits checked, 1 or 2
C_OVERSAMPLE, 16, En_Baud ticks per bit, 8 or 16
C_FIFO_DEPTH, 16, FIFO entries, power of 2, 2..256
C_FIFO_THRESHOLD, 8, level at which RX_Threshold_Hit asserts, 1..C_FIFO_DEPTH
C_IDLE_CHARS, 4, idle character times before timeout, 1..15

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
En_Baud  in  1  single-cycle oversample tick
RX  in  1  serial input, asynchronous to Clk
Read_RX_FIFO  in  1  pop FIFO head; ignored when empty
Reset_RX_FIFO  in  1  synchronous FIFO flush
RX_Data  out  C_DATA_BITS  FIFO head, LSB = first received bit
RX_Data_Present  out  1  FIFO not empty
RX_Buffer_Full  out  1  FIFO full
RX_Fill_Level  out  clog2(C_FIFO_DEPTH)+1  current entry count
RX_Threshold_Hit  out  1  RX_Fill_Level >= C_FIFO_THRESHOLD
RX_Frame_Error  out  1  1-cycle pulse
RX_Parity_Error  out  1  1-cycle pulse
RX_Overrun_Error  out  1  1-cycle pulse
RX_Break  out  1  1-cycle pulse
RX_Idle_Timeout  out  1  level

Behaviour:
- Reset_n low: every output 0, FIFO empty, FSM IDLE, both RX synchroniser flops set to 1. The reset is asynchronous. Clear any frame in progress with no pulses.
- RX passes through a 2-flop synchroniser (rxs). All sampling uses rxs on En_Baud cycles only.
- Tick counter tcnt runs 0..C_OVERSAMPLE-1. The bit value is the majority of rxs at tcnt = OS/2-1, OS/2 and OS/2+1, decided on the OS/2+1 tick.
- FSM states:
  - IDLE: rxs==0 on a tick -> START with tcnt=0.
  - START: majority 1 -> IDLE (false start, no outputs). Majority 0 -> DATA at the end of the bit.
  - DATA: shift in LSB-first for C_DATA_BITS bits -> PARITY if C_PARITY!=0, else STOP.
  - PARITY: compare the sampled bit against the expected value. Expected = XOR of data for even, its inverse for odd, 1 for mark, 0 for space.
  - STOP: C_STOP_BITS bits. On the decision of the final stop sample, go to IDLE (good frame) or WAIT_HIGH (error).
  - WAIT_HIGH: stay until rxs==1 on a tick, then IDLE. No new start is accepted while in WAIT_HIGH.
- Frame completion (decision tick of the last stop bit, call it cycle T):
  - All stop bits 1: request a FIFO write at T+1.
  - If the parity bit mismatched, still write the character and pulse RX_Parity_Error at T+1.
  - Any stop bit 0 with all data bits, parity bit and stop bits 0: pulse RX_Break at T+1. Nothing is written and RX_Frame_Error is not pulsed.
  - Any stop bit 0 otherwise: pulse RX_Frame_Error at T+1. Nothing is written.
- A stop bit of 0 ends the frame early. Go straight to WAIT_HIGH without sampling any remaining stop bit.
- FIFO:
  - First-word-fall-through. RX_Data_Present rises at T+2.
  - RX_Data is 0 when empty.
  - Read_RX_FIFO advances the head on the next edge.
- Write request while full and no simultaneous pop: drop the character and pulse RX_Overrun_Error. Write while full with a same-cycle pop: both happen, level unchanged, no overrun.
- Reset_RX_FIFO: level 0 on the next edge. A write request in the same cycle is dropped silently. The FSM is unaffected.
- Idle timer:
  - Counts En_Baud ticks while FSM==IDLE, rxs==1 and the FIFO is not empty.
  - Clears on a start detect, a pop, a flush or the FIFO going empty.
  - At C_IDLE_CHARS*C_OVERSAMPLE*(1+C_DATA_BITS+(C_PARITY!=0)+C_STOP_BITS) ticks, RX_Idle_Timeout goes to 1 and holds until one of the clear conditions occurs.
  - The counter saturates.
- Pointer and level arithmetic wraps modulo C_FIFO_DEPTH. The level has one extra bit so that full is distinguishable from empty.

Test Plan:
- 8N1, OS=16, En_Baud every 4 Clk, send 0xA5 -> RX_Data=0xA5, RX_Data_Present at T+2, level 1, no error pulses.
- C_PARITY=1 (even), send 0x03 with parity bit 1 -> 0x03 written and one RX_Parity_Error pulse. The same frame with parity 0 -> no pulse.
- Hold RX low for 5 ticks then high -> false start: FIFO unchanged, no pulses, next 0x5A received correctly.
- Hold RX low for 12 bit times, then high -> one RX_Break pulse, no RX_Frame_Error, nothing written. Next start accepted only after RX is high.
- C_FIFO_DEPTH=4, send 5 chars with no reads -> level 4, RX_Buffer_Full=1, 5th dropped with one RX_Overrun_Error pulse. Repeat with a pop on the write cycle -> no overrun, level stays 4.
- Two chars then idle -> RX_Idle_Timeout rises after 4x10x16 ticks and falls on the first Read_RX_FIFO. Separately, drive Reset_n low mid-DATA -> all outputs 0, next frame received cleanly.
